// File: rtl/aes_pkg.sv
// Shared AES constants: key schedule size, sequencer state encoding and the
// one-hot datapath command encoding.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam int unsigned RK_ADDR_W = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ROUND = 3'd2;
    localparam logic [2:0] ST_FINAL = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    // Bit order: {final, round, load}
    localparam logic [2:0] DP_NONE  = 3'b000;
    localparam logic [2:0] DP_LOAD  = 3'b001;
    localparam logic [2:0] DP_ROUND = 3'b010;
    localparam logic [2:0] DP_FINAL = 3'b100;

    function automatic logic [2:0] dp_cmd(input logic [2:0] state);
        case (state)
            ST_LOAD:  dp_cmd = DP_LOAD;
            ST_ROUND: dp_cmd = DP_ROUND;
            ST_FINAL: dp_cmd = DP_FINAL;
            default:  dp_cmd = DP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// AES encryption round sequencer: steps the round datapath through load, NR-1 full
// rounds and the final round, then holds the result under a valid/ready handshake.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NR     = AES_NR,
    parameter int unsigned ADDR_W = RK_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_loaded,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rk_addr,
    output logic              dp_load,
    output logic              dp_round_en,
    output logic              dp_final,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] RND_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RND_LAST = ADDR_W'(NR - 1);
    localparam logic [ADDR_W-1:0] RND_MAX  = ADDR_W'(NR);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] rnd_q, rnd_d;
    logic [ADDR_W-1:0] rk_addr_q, rk_addr_d;
    logic [2:0]        cmd;
    logic              accept;

    // HOLD can hand off and accept in the same cycle, hence the out_ready term.
    assign in_ready = key_loaded & ~abort &
                      ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready));
    assign accept   = in_valid & in_ready;

    // rk_addr is computed for the next state so it lines up with that state's strobe.
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        rk_addr_d = rk_addr_q;
        if (abort) begin
            state_d   = ST_IDLE;
            rnd_d     = '0;
            rk_addr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d   = ST_LOAD;
                        rk_addr_d = '0;
                    end
                end
                ST_LOAD: begin
                    state_d   = ST_ROUND;
                    rnd_d     = RND_ONE;
                    rk_addr_d = RND_ONE;
                end
                ST_ROUND: begin
                    rnd_d = rnd_q + RND_ONE;
                    if (rnd_q == RND_LAST) begin
                        state_d   = ST_FINAL;
                        rk_addr_d = RND_MAX;
                    end else begin
                        rk_addr_d = rnd_q + RND_ONE;
                    end
                end
                ST_FINAL: begin
                    state_d = ST_HOLD;
                    rnd_d   = '0;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d   = accept ? ST_LOAD : ST_IDLE;
                        rk_addr_d = '0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    rnd_d     = '0;
                    rk_addr_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rnd_q     <= '0;
            rk_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            rk_addr_q <= rk_addr_d;
        end
    end

    assign cmd         = dp_cmd(state_q);
    assign dp_load     = cmd[0];
    assign dp_round_en = cmd[1];
    assign dp_final    = cmd[2];
    assign busy        = |cmd;
    assign out_valid   = (state_q == ST_HOLD);
    assign rk_addr     = rk_addr_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed, table-driven bench for aes_round_sequencer (NR=10 instance plus an NR=4 instance).
module tb_aes_round_sequencer;

    typedef struct {
        logic       kl;
        logic       iv;
        logic       ordy;
        logic       ab;
        logic       irdy;
        logic       ovld;
        logic       ld;
        logic       re;
        logic       fin;
        logic [3:0] rk;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       key_loaded;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] rk_addr;
    logic       dp_load;
    logic       dp_round_en;
    logic       dp_final;
    logic       busy;

    logic       in_valid4;
    logic       in_ready4;
    logic       out_valid4;
    logic       out_ready4;
    logic [2:0] rk_addr4;
    logic       dp_load4;
    logic       dp_round_en4;
    logic       dp_final4;
    logic       busy4;
    logic       abort4;

    int n_chk;
    int n_fail;
    vec_t vecs[$];

    aes_round_sequencer #(.NR(10), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_loaded  (key_loaded),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rk_addr     (rk_addr),
        .dp_load     (dp_load),
        .dp_round_en (dp_round_en),
        .dp_final    (dp_final),
        .busy        (busy)
    );

    aes_round_sequencer #(.NR(4), .ADDR_W(3)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .key_loaded  (key_loaded),
        .abort       (abort4),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .out_valid   (out_valid4),
        .out_ready   (out_ready4),
        .rk_addr     (rk_addr4),
        .dp_load     (dp_load4),
        .dp_round_en (dp_round_en4),
        .dp_final    (dp_final4),
        .busy        (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic kl, input logic iv, input logic ordy, input logic ab,
                                input logic irdy, input logic ovld, input logic ld,
                                input logic re, input logic fin, input int rk);
        vec_t v;
        v.kl = kl; v.iv = iv; v.ordy = ordy; v.ab = ab;
        v.irdy = irdy; v.ovld = ovld; v.ld = ld; v.re = re; v.fin = fin;
        v.rk = 4'(rk);
        return v;
    endfunction

    // LOAD, rounds 1..9 and FINAL for the NR=10 instance.
    task automatic push_block(input logic kl, input logic iv, input logic ordy);
        vecs.push_back(mk(kl, iv, ordy, 0, 0, 0, 1, 0, 0, 0));
        for (int r = 1; r <= 9; r++) vecs.push_back(mk(kl, iv, ordy, 0, 0, 0, 0, 1, 0, r));
        vecs.push_back(mk(kl, iv, ordy, 0, 0, 0, 0, 0, 1, 10));
    endtask

    task automatic step(input vec_t v, input int idx);
        key_loaded = v.kl;
        in_valid   = v.iv;
        out_ready  = v.ordy;
        abort      = v.ab;
        #1;
        chk($sformatf("v%0d in_ready", idx), in_ready, v.irdy);
        chk($sformatf("v%0d out_valid", idx), out_valid, v.ovld);
        chk($sformatf("v%0d dp_load", idx), dp_load, v.ld);
        chk($sformatf("v%0d dp_round_en", idx), dp_round_en, v.re);
        chk($sformatf("v%0d dp_final", idx), dp_final, v.fin);
        chk($sformatf("v%0d busy", idx), busy, v.ld | v.re | v.fin);
        chk($sformatf("v%0d rk_addr", idx), rk_addr, v.rk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        key_loaded = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; abort4 = 1'b0;

        // Test 1: single block, out_ready high
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        push_block(1, 0, 1);
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 10));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        // Test 2: key not loaded blocks acceptance
        for (int i = 0; i < 20; i++) vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        push_block(1, 0, 1);
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 10));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        // Test 3: back-to-back, HOLD goes straight to LOAD
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        push_block(1, 1, 1);
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 10));
        push_block(1, 1, 1);
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 10));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        // Test 4: backpressure in HOLD
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        push_block(1, 0, 1);
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 10));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 10));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // Test 5: abort in ROUND (rk_addr 4), then abort in HOLD
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        for (int r = 1; r <= 3; r++) vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 0, r));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 1, 0, 4));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        push_block(1, 0, 1);
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 10));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        // key_loaded drops mid-block: block completes, drains, no new accept
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        push_block(0, 1, 1);
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 10));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));

        // Reset state
        #2;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset rk_addr", rk_addr, 0);
        chk("reset strobes", {dp_load, dp_round_en, dp_final}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) step(vecs[i], i);

        // Test 6a: asynchronous reset while in ROUND
        key_loaded = 1'b1; in_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre-rst dp_round_en", dp_round_en, 1);
        chk("pre-rst rk_addr", rk_addr, 3);
        rst = 1'b1;
        #1;
        chk("async rst dp_round_en", dp_round_en, 0);
        chk("async rst busy", busy, 0);
        chk("async rst rk_addr", rk_addr, 0);
        chk("async rst out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk($sformatf("post-rst idle out_valid c%0d", i), out_valid, 0);
            chk($sformatf("post-rst idle busy c%0d", i), busy, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;

        // Test 6b: NR=4 instance single block
        in_valid4 = 1'b1;
        out_ready4 = 1'b1;
        #1;
        chk("nr4 in_ready", in_ready4, 1);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            #1;
            chk($sformatf("nr4 k%0d dp_load", k), dp_load4, k == 0);
            chk($sformatf("nr4 k%0d dp_round_en", k), dp_round_en4, k >= 1 && k <= 3);
            chk($sformatf("nr4 k%0d dp_final", k), dp_final4, k == 4);
            chk($sformatf("nr4 k%0d out_valid", k), out_valid4, k == 5);
            chk($sformatf("nr4 k%0d busy", k), busy4, k <= 4);
            chk($sformatf("nr4 k%0d rk_addr", k), rk_addr4,
                (k == 0 || k == 6) ? 0 : (k <= 4 ? k : 4));
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
